seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial sequence detector, successor to the fixed 10010 Moore detector. Samples a serial input `w` on an internal slow tick and compares the last `PAT_LEN` samples against a runtime-loadable pattern. Supports overlapping and non-overlapping detection, selected at runtime, and an optional saturating match counter. Sits between a debounced switch/serial source and board LEDs or downstream logic.

## Interface
- `PAT_LEN`, 5: pattern length in bits; legal range 2..32.
- `PAT_INIT`, 5'b10010: pattern value after reset.
- `TICK_DIV`, 200_000_000: clock cycles per sample; legal range ≥1 (1 = sample every cycle).
- `CNT_W`, 8: match counter width; only used with `SEQ_DET_COUNT_EN`.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `w`  in  1  serial data input.
- `pat_in`  in  PAT_LEN  new pattern; MSB is the first bit of the sequence.
- `pat_load`  in  1  one-cycle strobe; loads `pat_in`.
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `sample_tick`  out  1  high for exactly one `clk` cycle per sample period.
- `w_sampled`  out  1  last captured value of `w`.
- `z`  out  1  match flag (Moore, registered).
- `fill`  out  $clog2(PAT_LEN+1)  number of valid history bits.
- `match_count`  out  CNT_W  saturating match count; present only with `SEQ_DET_COUNT_EN`.

## Operation
- Divider `div` counts from 0 to TICK_DIV-1 and wraps. `sample_tick` = (`div` == TICK_DIV-1). When TICK_DIV=1, `sample_tick` is constant 1 after reset.
- On a clock edge with `sample_tick`=1 and `pat_load`=0:
  - `hist` <= {hist[PAT_LEN-2:0], w}.
  - `w_sampled` <= w.
  - `fill` <= min(fill+1, PAT_LEN).
- Match: next `fill` == PAT_LEN and next `hist` == `pat`. On a match, `z` <= 1; otherwise `z` <= 0 on every sample edge. `z` holds its value between ticks.
- Non-overlap (`overlap`=0): a match also sets `fill` <= 0, so the next match needs PAT_LEN fresh samples. Overlap mode leaves `fill` at PAT_LEN.
- The `fill` gate prevents false matches on reset-zero history, e.g. for an all-zero pattern.
- `overlap` is read on every sample edge, so changing it between ticks is legal.
- `pat_load`=1: `pat` <= `pat_in`; `hist`, `fill` and `z` are cleared. The divider keeps running. If a tick occurs in the same cycle, the load wins and that sample is discarded; `w_sampled` still updates.
- Reset values:
  - `div`=0, `hist`=0, `fill`=0, `pat`=PAT_INIT.
  - `z`=0, `w_sampled`=0, `match_count`=0.
  - `sample_tick`=0 when TICK_DIV>1.
- Reset asserted mid-sequence discards all history immediately, with no clock required.

## Timing
- Sample latency: `w` is captured at the rising edge that ends the `sample_tick` cycle.
- `z` rises at that same edge, zero cycles after the final bit is captured. It stays high for exactly TICK_DIV cycles, i.e. until the next sample edge.
- First sample edge after reset release: the TICK_DIV-th rising edge.
- `pat_load` takes effect at the edge where it is sampled high. `z` is low from the following cycle.
- No handshake back-pressure; `w` must be stable around the sample edge.

## Configuration
- `SEQ_DET_COUNT_EN` defined:
  - `match_count` port and register exist.
  - Increments by 1 on every match edge and saturates at 2^CNT_W-1.
  - Cleared by reset and by `pat_load`.
- Undefined: the port and register are omitted entirely; all other behaviour is identical.

## Structure
- Package `seq_det_pkg` holds:
  - the default constants `SEQ_DET_PAT_LEN_DEF`, `SEQ_DET_PAT_DEF` and `SEQ_DET_TICK_DIV_DEF`;
  - a function computing the `fill` width.
- Sub-module `tick_gen` (parameter TICK_DIV; ports clk, reset, tick) owns the divider. The detector instantiates it once.
- Detector body: history shift register, fill counter, compare, and the `z`/counter registers.

## Test plan
Default bench settings: PAT_LEN=5, PAT_INIT=10010, TICK_DIV=4.
- Reset check: hold `reset` for 3 cycles → `z`=0, `fill`=0, `w_sampled`=0. First `sample_tick` appears on cycle 4 after release.
- Overlap: `overlap`=1, stream 1,0,0,1,0,0,1,0 → `z` high after samples 5 and 8, each time for 4 cycles. `match_count`=2.
- Non-overlap: same stream with `overlap`=0 → `z` high only after sample 5. `fill` is 3 after sample 8. `match_count`=1.
- All-zero pattern: load `pat_in`=00000, then feed zeros → no match on samples 1–4. `z` high on sample 5 and on every later sample (overlap=1).
- Load collision: assert `pat_load` (pat_in=11011) in a tick cycle mid-stream → that sample is dropped, `fill`=0, `z`=0. Stream 1,1,0,1,1 → match on its fifth sample.
- Async reset mid-match: assert `reset` between clock edges while `z`=1 → `z` and `fill` go to 0 before the next edge. With CNT_W=2, 5 matches → `match_count`=3 (saturated).

Source files
------------

// File: rtl/seq_det_pkg.sv
// ============================================================================
// Package : seq_det_pkg
// Brief   : Shared defaults, detection-mode type and fill-width helper.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    localparam int unsigned SEQ_DET_PAT_LEN_DEF  = 5;
    localparam logic [SEQ_DET_PAT_LEN_DEF-1:0] SEQ_DET_PAT_DEF = 5'b10010;
    localparam int unsigned SEQ_DET_TICK_DIV_DEF = 200_000_000;

    typedef enum logic {
        DET_NON_OVERLAP = 1'b0,
        DET_OVERLAP     = 1'b1
    } det_mode_e;

    // Width needed to count 0..pat_len valid history bits.
    function automatic int unsigned seq_det_fill_w(input int unsigned pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_detector_param_tick_gen.sv
// ============================================================================
// Module : tick_gen
// Brief  : Free-running divider producing a one-cycle sample tick every
//          TICK_DIV clocks; first tick ends at the TICK_DIV-th edge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen
    import seq_det_pkg::*;
#(
    parameter int unsigned TICK_DIV = SEQ_DET_TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    generate
        if (TICK_DIV <= 1) begin : g_every_cycle
            logic tick_q;

            // Held high through reset so the very first edge is a sample edge.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tick_q <= 1'b1;
                end else begin
                    tick_q <= 1'b1;
                end
            end

            assign tick = tick_q;
        end else begin : g_divider
            localparam int unsigned C_DW = $clog2(TICK_DIV);
            localparam logic [C_DW-1:0] C_LAST = C_DW'(TICK_DIV - 1);

            logic [C_DW-1:0] div_q;
            logic [C_DW-1:0] div_d;

            always_comb begin
                div_d = div_q + 1'b1;
                if (div_q == C_LAST) begin
                    div_d = '0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_d;
                end
            end

            assign tick = (div_q == C_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module : seq_detector_param
// Brief  : Runtime-loadable serial pattern detector, overlapping or
//          non-overlapping, sampling w on a divided tick.
// Config : define SEQ_DET_COUNT_EN to add the saturating match_count output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_LEN  = SEQ_DET_PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0]   PAT_INIT = PAT_LEN'(SEQ_DET_PAT_DEF),
    parameter int unsigned          TICK_DIV = SEQ_DET_TICK_DIV_DEF
`ifdef SEQ_DET_COUNT_EN
    ,
    parameter int unsigned          CNT_W    = 8
`endif
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                w,
    input  logic [PAT_LEN-1:0]                  pat_in,
    input  logic                                pat_load,
    input  logic                                overlap,
    output logic                                sample_tick,
    output logic                                w_sampled,
    output logic                                z,
    output logic [seq_det_fill_w(PAT_LEN)-1:0]  fill
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0]                    match_count
`endif
);

    localparam int unsigned      C_FW   = seq_det_fill_w(PAT_LEN);
    localparam logic [C_FW-1:0]  C_FULL = C_FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic [C_FW-1:0]    fill_q, fill_d;
    logic               z_q,    z_d;
    logic               ws_q,   ws_d;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
`endif

    logic [PAT_LEN-1:0] hist_shift;
    logic [C_FW-1:0]    fill_inc;
    logic               match;
    det_mode_e          mode;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (sample_tick)
    );

    assign mode       = det_mode_e'(overlap);
    assign hist_shift = {hist_q[PAT_LEN-2:0], w};
    assign fill_inc   = (fill_q == C_FULL) ? C_FULL : fill_q + 1'b1;
    // The fill gate keeps reset-zero history from matching an all-zero pattern.
    assign match      = (fill_inc == C_FULL) && (hist_shift == pat_q);

    always_comb begin
        hist_d = hist_q;
        pat_d  = pat_q;
        fill_d = fill_q;
        z_d    = z_q;
        ws_d   = ws_q;
`ifdef SEQ_DET_COUNT_EN
        cnt_d  = cnt_q;
`endif
        if (sample_tick) begin
            ws_d = w;
        end

        // A load beats a coincident tick: that sample is dropped.
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
            z_d    = 1'b0;
`ifdef SEQ_DET_COUNT_EN
            cnt_d  = '0;
`endif
        end else if (sample_tick) begin
            hist_d = hist_shift;
            z_d    = match;
            fill_d = fill_inc;
            if (match && (mode == DET_NON_OVERLAP)) begin
                fill_d = '0;
            end
`ifdef SEQ_DET_COUNT_EN
            if (match && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            pat_q  <= PAT_INIT;
            fill_q <= '0;
            z_q    <= 1'b0;
            ws_q   <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
            cnt_q  <= '0;
`endif
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            ws_q   <= ws_d;
`ifdef SEQ_DET_COUNT_EN
            cnt_q  <= cnt_d;
`endif
        end
    end

    assign z         = z_q;
    assign w_sampled = ws_q;
    assign fill      = fill_q;
`ifdef SEQ_DET_COUNT_EN
    assign match_count = cnt_q;
`endif

endmodule

`default_nettype wire
